// File: rtl/regfile_scoreboard.sv
// 32-entry integer register file with bypassed combinational reads and a
// pending-write scoreboard that stalls issue on RAW/WAW hazards.

module regfile_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pend_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] entry;
  logic [NUM_REGS-1:0]                 busy;
  logic [NUM_REGS-1:0]                 busy_nxt;
  logic                                wb_live;
  logic                                accept;
  logic                                accept_set;
  logic                                wb_clear;

  assign entry[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
    regfile_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .clk   (clk),
      .clr_n (clr_n),
      .en    (we && (wr_addr == ADDR_WIDTH'(g))),
      .d     (wr_data),
      .q     (entry[g])
    );
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0)                 return '0;
    else if (we && wr_addr == a) return wr_data;
    else                         return entry[a];
  endfunction

  // A busy index stops hazarding in the very cycle its writeback arrives.
  function automatic logic hazard(input logic [ADDR_WIDTH-1:0] a);
    return busy[a] && !(we && wr_addr == a);
  endfunction

  function automatic logic [ADDR_WIDTH:0] sat_step(input logic [ADDR_WIDTH:0] c,
                                                    input logic inc, input logic dec);
    if (inc && !dec)      return (c == CNT_MAX) ? c : c + 1'b1;
    else if (dec && !inc) return (c == '0) ? c : c - 1'b1;
    else                  return c;
  endfunction

  assign rs1_data = clr_n ? read_port(rs1_addr) : '0;
  assign rs2_data = clr_n ? read_port(rs2_addr) : '0;
  assign stall    = clr_n && iss_valid &&
                    (hazard(rs1_addr) || hazard(rs2_addr) || hazard(iss_rd));

  assign wb_live    = we && (wr_addr != '0);
  assign accept     = iss_valid && !stall && (iss_rd != '0);
  // Counter moves only on real 0->1 / 1->0 transitions so it tracks popcount(busy).
  assign accept_set = accept && !busy[iss_rd];
  assign wb_clear   = wb_live && busy[wr_addr] && !(accept && iss_rd == wr_addr);

  always_comb begin
    busy_nxt = busy;
    if (wb_live) busy_nxt[wr_addr] = 1'b0;
    if (accept)  busy_nxt[iss_rd]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= sat_step(pend_cnt, accept_set, wb_clear);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array-based
// reference of register contents and pending destinations.

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        stall;
  logic [5:0]  pend_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_rf   [32];
  bit          m_busy [32];

  regfile_scoreboard dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .stall     (stall),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic w,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (w && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic bit m_haz(input logic [4:0] a, input logic w, input logic [4:0] wa);
    return (a != 0) && m_busy[a] && !(w && wa == a);
  endfunction

  // Drive one cycle of stimulus, check combinational outputs and the counter,
  // then advance the reference across the rising edge.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic iv, input logic [4:0] rd);
    bit          e_stall;
    logic [31:0] e1, e2;
    we = w; wr_addr = wa; wr_data = wd;
    rs1_addr = a1; rs2_addr = a2; iss_valid = iv; iss_rd = rd;
    e_stall = iv && (m_haz(a1, w, wa) || m_haz(a2, w, wa) || m_haz(rd, w, wa));
    e1 = m_read(a1, w, wa, wd);
    e2 = m_read(a2, w, wa, wd);
    #3;
    chk_eq("rs1_data", rs1_data, e1);
    chk_eq("rs2_data", rs2_data, e2);
    chk_eq("stall", stall, e_stall);
    chk_eq("pend_cnt", pend_cnt, m_cnt());
    @(posedge clk);
    if (w && wa != 0) begin
      m_rf[wa]   = wd;
      m_busy[wa] = 1'b0;
    end
    if (iv && !e_stall && rd != 0) m_busy[rd] = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic pulse_reset();
    clr_n = 1'b0;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0; we = 0; wr_addr = 0; wr_data = 0;
    rs1_addr = 0; rs2_addr = 0; iss_valid = 0; iss_rd = 0;
    m_reset();

    // reset held while writes and issues toggle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      we = (i % 2 == 0); wr_addr = 5'd3; wr_data = $urandom;
      rs1_addr = 5'd3; rs2_addr = 5'd3; iss_valid = 1'b1; iss_rd = 5'd3;
      #3;
      chk_eq("rst_rs1", rs1_data, 32'h0);
      chk_eq("rst_rs2", rs2_data, 32'h0);
      chk_eq("rst_stall", stall, 1'b0);
      chk_eq("rst_pend", pend_cnt, 6'd0);
    end
    @(posedge clk);
    #1;
    we = 0; iss_valid = 0;
    clr_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);

    // write with same-cycle bypass, then stored read
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);

    // r0 writes discarded, r0 issue accepted without marking busy
    step(1'b1, 5'd0, 32'hCAFEBABE, 5'd0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    idle();

    // RAW hazard resolved by writeback in the same cycle
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd0);
    step(1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd7, 1'b1, 5'd0);
    idle();

    // accept and writeback colliding on one index: busy stays set
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
    step(1'b1, 5'd9, 32'h0000_0099, 5'd0, 5'd0, 1'b1, 5'd9);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    step(1'b1, 5'd9, 32'h0000_0AAA, 5'd9, 5'd0, 1'b0, 5'd0);
    idle();

    // randomized traffic concentrated on a few indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, a1, a2, rd;
      wa = (i % 5 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      rd = (i % 7 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), wa, $urandom, a1, a2,
           ($urandom_range(0, 9) < 6), rd);
    end

    // fill the scoreboard, then confirm any issue stalls and async reset clears it
    pulse_reset();
    for (int r = 1; r < 32; r++) step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'(r));
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd12);
    iss_valid = 1'b1; rs1_addr = 5'd4;
    #3;
    chk_eq("full_stall", stall, 1'b1);
    chk_eq("full_pend", pend_cnt, 6'd31);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk_eq("async_stall", stall, 1'b0);
    chk_eq("async_pend", pend_cnt, 6'd0);
    chk_eq("async_rs1", rs1_data, 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b1, 5'd4);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
